imem_port_arbiter: RTL

- Shares the single-read-port instruction memory (instruction_rom, SIZE words) between the sr_cpu fetch port and a debug/loader read port.
- Arbitrates each cycle, registers the winning address to the memory, and tracks in-flight reads through a fixed-latency pipeline.
- Routes each returned word back to its owner.
- Sits between sr_cpu/debug logic and the ROM; the CPU stalls fetch while its request is not granted.

---
 rtl/imem_arb_pkg.sv | 25 ++
 rtl/imem_arb_owner_pipe.sv | 39 +++
 rtl/imem_port_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and constants for the instruction-memory port arbiter.
package imem_arb_pkg;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_t;

  typedef enum logic {
    CPU_PRI   = 1'b0,
    DBG_FORCE = 1'b1
  } arb_state_t;

  // Deepest ROM read latency the return pipeline is expected to cover.
  localparam int unsigned MAX_MEM_LATENCY = 4;

  // Width of the CPU run counter; holds MAX_CPU_RUN up to 15.
  localparam int unsigned RUN_CNT_W = 4;

  // Saturating increment for 32-bit event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/imem_arb_owner_pipe.sv
// imem_arb_owner_pipe: valid/owner shift register that follows each issued read
// through the fixed-latency ROM so the returned word can be routed to its owner.
module imem_arb_owner_pipe
  import imem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid_i,
  input  owner_t in_owner_i,
  output logic   out_valid_o,
  output owner_t out_owner_o,
  output logic   any_valid_o
);

  logic [DEPTH-1:0] valid_q;
  owner_t           owner_q [DEPTH];

  // Shift one slot per cycle; reset drops every read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) owner_q[i] <= OWNER_CPU;
    end else begin
      valid_q[0] <= in_valid_i;
      owner_q[0] <= in_owner_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_owner_o = owner_q[DEPTH-1];
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single read port of the instruction ROM between
// the CPU fetch port and a debug/loader port. CPU has priority, but debug is
// forced through after MAX_CPU_RUN consecutive CPU wins while it waits.
// Optional grant/conflict statistics: define IMEM_ARB_STATS_EN.
//
// Handshake: a request is accepted in the cycle where req && gnt; gnt is
// combinational, at most one gnt is high per cycle, and a requester holds req
// and addr stable until it sees gnt. Each accepted read returns one cycle-wide
// rvalid pulse exactly MEM_LATENCY+1 cycles later, in issue order.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MAX_CPU_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_cpu_grants,
  output logic [31:0]       stat_dbg_grants,
  output logic [31:0]       stat_conflicts
`endif
);

  localparam logic [RUN_CNT_W-1:0] MAX_RUN = RUN_CNT_W'(MAX_CPU_RUN);

  arb_state_t           state_q, state_d;
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic                 cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0]    cpu_rdata_q, dbg_rdata_q;
  logic                 accept;
  owner_t               win_owner;
  logic                 ret_valid;
  owner_t               ret_owner;
  logic                 pipe_busy;

  // Arbitration FSM: grants, run counting and the one-slot debug override.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    case (state_q)
      CPU_PRI: begin
        if (cpu_req)      cpu_gnt = 1'b1;
        else if (dbg_req) dbg_gnt = 1'b1;
      end
      DBG_FORCE: begin
        if (dbg_req)      dbg_gnt = 1'b1;
        else if (cpu_req) cpu_gnt = 1'b1;
        state_d = CPU_PRI;
      end
      default: state_d = CPU_PRI;
    endcase
    if (dbg_gnt || !dbg_req) begin
      run_cnt_d = '0;
    end else if (cpu_gnt) begin
      run_cnt_d = run_cnt_q + 1'b1;
      if (run_cnt_d == MAX_RUN) state_d = DBG_FORCE;
    end
  end

  // Arbiter state and run counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CPU_PRI;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign accept    = cpu_gnt | dbg_gnt;
  assign win_owner = dbg_gnt ? OWNER_DBG : OWNER_CPU;

  // Issue: register the winning address; hold it while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
    end else if (accept) begin
      mem_addr_q <= dbg_gnt ? dbg_addr : cpu_addr;
    end
  end

  imem_arb_owner_pipe #(
    .DEPTH(MEM_LATENCY)
  ) u_owner_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (accept),
    .in_owner_i (win_owner),
    .out_valid_o(ret_valid),
    .out_owner_o(ret_owner),
    .any_valid_o(pipe_busy)
  );

  // Return: capture ROM data for the owner and pulse its rvalid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      if (ret_valid) begin
        if (ret_owner == OWNER_DBG) begin
          dbg_rvalid_q <= 1'b1;
          dbg_rdata_q  <= mem_rdata;
        end else begin
          cpu_rvalid_q <= 1'b1;
          cpu_rdata_q  <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr   = mem_addr_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign busy       = pipe_busy;

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stat_cpu_q, stat_dbg_q, stat_conf_q;

  // Saturating counters of grants per port and of cycles with both requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cpu_q  <= '0;
      stat_dbg_q  <= '0;
      stat_conf_q <= '0;
    end else begin
      if (cpu_gnt)           stat_cpu_q  <= sat_inc32(stat_cpu_q);
      if (dbg_gnt)           stat_dbg_q  <= sat_inc32(stat_dbg_q);
      if (cpu_req && dbg_req) stat_conf_q <= sat_inc32(stat_conf_q);
    end
  end

  assign stat_cpu_grants = stat_cpu_q;
  assign stat_dbg_grants = stat_dbg_q;
  assign stat_conflicts  = stat_conf_q;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule
